// File: rtl/main_memory_pkg.sv
// Shared widths, FSM state encoding and the saturating counter helper
// for the main_memory bus slave.
package main_memory_pkg;

  localparam int DATA_W        = 256;
  localparam int ADDR_W        = 16;
  localparam int DEV_W         = 4;
  localparam int INDEX_W       = ADDR_W - DEV_W;
  localparam int CNT_W         = 16;
  localparam int DEFAULT_DEPTH = 12;

  typedef enum logic [1:0] {
    IDLE,
    RD_ARRAY,
    RD_DRIVE,
    WR_ACK
  } memState_t;

  // Counters stick at all-ones instead of wrapping back to zero
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
    return (&value) ? value : value + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/main_memory_if.sv
// Bus bundle between a master and the main_memory slave.
interface main_memory_if;
  import main_memory_pkg::*;

  logic [DATA_W-1:0] DataIn;
  logic [ADDR_W-1:0] address;
  logic              nRead;
  logic              nWrite;
  logic [DATA_W-1:0] DataOut;
  logic              Ack;
  logic              Err;
  logic [CNT_W-1:0]  ReadCount;
  logic [CNT_W-1:0]  WriteCount;

  modport master (
    output DataIn, address, nRead, nWrite,
    input  DataOut, Ack, Err, ReadCount, WriteCount
  );

  modport slave (
    input  DataIn, address, nRead, nWrite,
    output DataOut, Ack, Err, ReadCount, WriteCount
  );

endinterface

// File: rtl/main_memory_bus_cmd_edge.sv
// Falling-edge detection on the active-low bus commands, so a held-low
// command produces a single request.
module bus_cmd_edge (
  input  logic Clk,
  input  logic Reset,
  input  logic nRead,
  input  logic nWrite,
  output logic readEdge,
  output logic writeEdge
);

  logic prevRead;
  logic prevWrite;

  // Samples reset high so a command held low through reset release is seen as new
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      prevRead  <= 1'b1;
      prevWrite <= 1'b1;
    end else begin
      prevRead  <= nRead;
      prevWrite <= nWrite;
    end
  end

  assign readEdge  = !nRead  && prevRead;
  assign writeEdge = !nWrite && prevWrite;

endmodule

// File: rtl/main_memory.sv
// Word-addressed 256-bit memory slave with fixed-latency read/write
// handshake, sticky error flag and saturating operation counters.
module main_memory
  import main_memory_pkg::*;
#(
  parameter int               DEPTH  = DEFAULT_DEPTH,
  parameter logic [DEV_W-1:0] DEV_ID = 4'h0
) (
  input logic          Clk,
  input logic          Reset,
  main_memory_if.slave bus
);

  localparam int                 IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [INDEX_W-1:0] DEPTH_LIMIT = INDEX_W'(DEPTH);

  logic [DATA_W-1:0] MainMemory [DEPTH];

  memState_t          state;
  memState_t          nextState;
  logic               readEdge;
  logic               writeEdge;
  logic               devMatch;
  logic               readReq;
  logic               writeReq;
  logic               inRange;
  logic               isIdle;
  logic               acceptRead;
  logic               acceptWrite;
  logic               errEvent;
  logic [INDEX_W-1:0] wordIndex;
  logic [IDX_W-1:0]   arrayIndex;
  logic [IDX_W-1:0]   readIndex;
  logic               readInRange;
  logic [DATA_W-1:0]  readData;
  logic [CNT_W-1:0]   readCount;
  logic [CNT_W-1:0]   writeCount;
  logic               errFlag;
  logic               ackOut;
  logic [DATA_W-1:0]  dataOut;

  bus_cmd_edge cmdEdge (
    .Clk       (Clk),
    .Reset     (Reset),
    .nRead     (bus.nRead),
    .nWrite    (bus.nWrite),
    .readEdge  (readEdge),
    .writeEdge (writeEdge)
  );

  assign devMatch   = (bus.address[ADDR_W-1 -: DEV_W] == DEV_ID);
  assign wordIndex  = bus.address[INDEX_W-1:0];
  assign arrayIndex = wordIndex[IDX_W-1:0];
  assign inRange    = (wordIndex < DEPTH_LIMIT);
  assign readReq    = readEdge && devMatch;
  assign writeReq   = writeEdge && devMatch;
  assign isIdle     = (state == IDLE);

  // A simultaneous read+write is a collision: neither is accepted
  assign acceptRead  = isIdle && readReq && !writeReq;
  assign acceptWrite = isIdle && writeReq && !readReq;
  assign errEvent    = (readReq || writeReq) &&
                       (!isIdle || (readReq && writeReq) || !inRange);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (acceptRead) begin
          nextState = RD_ARRAY;
        end else if (acceptWrite) begin
          nextState = WR_ACK;
        end
      end
      RD_ARRAY: nextState = RD_DRIVE;
      RD_DRIVE: nextState = IDLE;
      WR_ACK:   nextState = IDLE;
      default:  nextState = IDLE;
    endcase
  end

  always_comb begin
    ackOut  = 1'b0;
    dataOut = '0;
    if (state == RD_DRIVE) begin
      ackOut  = 1'b1;
      dataOut = readData;
    end else if (state == WR_ACK) begin
      ackOut = 1'b1;
    end
  end

  // Writes commit on the accept edge; reads fetch the array one cycle later
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        MainMemory[i] <= '0;
      end
      readIndex   <= '0;
      readInRange <= 1'b0;
      readData    <= '0;
      readCount   <= '0;
      writeCount  <= '0;
      errFlag     <= 1'b0;
    end else begin
      if (acceptWrite) begin
        if (inRange) begin
          MainMemory[arrayIndex] <= bus.DataIn;
        end
        writeCount <= satInc(writeCount);
      end
      if (acceptRead) begin
        readIndex   <= arrayIndex;
        readInRange <= inRange;
      end
      if (state == RD_ARRAY) begin
        readData  <= readInRange ? MainMemory[readIndex] : '0;
        readCount <= satInc(readCount);
      end
      if (errEvent) begin
        errFlag <= 1'b1;
      end
    end
  end

  assign bus.Ack        = ackOut;
  assign bus.DataOut    = dataOut;
  assign bus.Err        = errFlag;
  assign bus.ReadCount  = readCount;
  assign bus.WriteCount = writeCount;

endmodule

// File: tb/tb_main_memory.sv
// Directed self-checking bench for main_memory: handshake latency, held
// commands, range/device filtering, collisions, reset abort, saturation.
module tb_main_memory;
  import main_memory_pkg::*;

  localparam logic [255:0] PAT_A = {8{32'hA5A5_0001}};
  localparam logic [255:0] PAT_B = {8{32'h5A5A_0002}};
  localparam logic [255:0] PAT_C = {4{64'hDEAD_BEEF_0BAD_F00D}};

  logic Clk = 1'b0;
  logic Reset;
  int   checks   = 0;
  int   failures = 0;

  main_memory_if bus ();

  main_memory #(.DEPTH(12), .DEV_ID(4'h0)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  task automatic applyReset();
    @(negedge Clk);
    Reset      = 1'b1;
    bus.nRead  = 1'b1;
    bus.nWrite = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic doWrite(input logic [15:0] a, input logic [255:0] d);
    @(negedge Clk);
    bus.address = a;
    bus.DataIn  = d;
    bus.nWrite  = 1'b0;
    @(negedge Clk);
    bus.nWrite = 1'b1;
    @(negedge Clk);
  endtask

  task automatic doRead(input logic [15:0] a, output logic [255:0] d, output logic ack);
    @(negedge Clk);
    bus.address = a;
    bus.nRead   = 1'b0;
    @(negedge Clk);
    bus.nRead = 1'b1;
    @(negedge Clk);
    d   = bus.DataOut;
    ack = bus.Ack;
    @(negedge Clk);
  endtask

  task automatic test_reset();
    applyReset();
    checks++; if (bus.Ack !== 1'b0) begin failures++; $display("[TB] FAIL reset_ack: got %b expected 0", bus.Ack); end
    checks++; if (bus.DataOut !== 256'h0) begin failures++; $display("[TB] FAIL reset_data: got %h expected 0", bus.DataOut); end
    checks++; if (bus.Err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %b expected 0", bus.Err); end
    checks++; if (bus.ReadCount !== 16'h0 || bus.WriteCount !== 16'h0) begin failures++; $display("[TB] FAIL reset_counts: got r=%h w=%h expected 0/0", bus.ReadCount, bus.WriteCount); end
  endtask

  task automatic test_write_read();
    logic [255:0] d;
    logic         a;
    applyReset();
    @(negedge Clk);
    bus.address = 16'h0003;
    bus.DataIn  = 256'h1234;
    bus.nWrite  = 1'b0;
    @(negedge Clk);
    checks++; if (bus.Ack !== 1'b1) begin failures++; $display("[TB] FAIL wr_ack: got %b expected 1", bus.Ack); end
    bus.nWrite = 1'b1;
    @(negedge Clk);
    checks++; if (bus.Ack !== 1'b0) begin failures++; $display("[TB] FAIL wr_ack_pulse: got %b expected 0", bus.Ack); end
    bus.nRead = 1'b0;
    @(negedge Clk);
    checks++; if (bus.Ack !== 1'b0) begin failures++; $display("[TB] FAIL rd_array_noack: got %b expected 0", bus.Ack); end
    bus.nRead = 1'b1;
    @(negedge Clk);
    checks++; if (bus.Ack !== 1'b1 || bus.DataOut !== 256'h1234) begin failures++; $display("[TB] FAIL rd_data: got ack=%b data=%h expected ack=1 data=1234", bus.Ack, bus.DataOut); end
    @(negedge Clk);
    checks++; if (bus.Ack !== 1'b0 || bus.DataOut !== 256'h0) begin failures++; $display("[TB] FAIL rd_release: got ack=%b data=%h expected 0/0", bus.Ack, bus.DataOut); end
    checks++; if (bus.WriteCount !== 16'd1 || bus.ReadCount !== 16'd1 || bus.Err !== 1'b0) begin failures++; $display("[TB] FAIL wr_rd_counts: got w=%h r=%h err=%b expected 1/1/0", bus.WriteCount, bus.ReadCount, bus.Err); end
    doWrite(16'h000B, PAT_C);
    doWrite(16'h0000, PAT_A);
    doRead(16'h000B, d, a);
    checks++; if (a !== 1'b1 || d !== PAT_C) begin failures++; $display("[TB] FAIL last_word: got ack=%b data=%h expected ack=1 data=%h", a, d, PAT_C); end
    doRead(16'h0000, d, a);
    checks++; if (a !== 1'b1 || d !== PAT_A) begin failures++; $display("[TB] FAIL first_word: got ack=%b data=%h expected ack=1 data=%h", a, d, PAT_A); end
    doRead(16'h0003, d, a);
    checks++; if (d !== 256'h1234) begin failures++; $display("[TB] FAIL word3_kept: got %h expected 1234", d); end
  endtask

  task automatic test_held_read();
    int acks = 0;
    applyReset();
    @(negedge Clk);
    bus.address = 16'h0000;
    bus.nRead   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      if (bus.Ack === 1'b1) acks++;
    end
    bus.nRead = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      if (bus.Ack === 1'b1) acks++;
    end
    checks++; if (acks != 1) begin failures++; $display("[TB] FAIL held_read_acks: got %0d expected 1", acks); end
    checks++; if (bus.ReadCount !== 16'd1 || bus.Err !== 1'b0) begin failures++; $display("[TB] FAIL held_read_state: got r=%h err=%b expected 1/0", bus.ReadCount, bus.Err); end
  endtask

  task automatic test_out_of_range();
    logic [255:0] d;
    logic         a;
    applyReset();
    doWrite(16'h0000, PAT_A);
    doRead(16'h000C, d, a);
    checks++; if (a !== 1'b1 || d !== 256'h0) begin failures++; $display("[TB] FAIL oob_read: got ack=%b data=%h expected ack=1 data=0", a, d); end
    checks++; if (bus.Err !== 1'b1 || bus.ReadCount !== 16'd1) begin failures++; $display("[TB] FAIL oob_read_flags: got err=%b r=%h expected 1/1", bus.Err, bus.ReadCount); end
    doWrite(16'h000F, PAT_B);
    checks++; if (bus.Err !== 1'b1 || bus.WriteCount !== 16'd2) begin failures++; $display("[TB] FAIL oob_write_flags: got err=%b w=%h expected 1/2", bus.Err, bus.WriteCount); end
    doRead(16'h0000, d, a);
    checks++; if (d !== PAT_A) begin failures++; $display("[TB] FAIL oob_mem_intact: got %h expected %h", d, PAT_A); end
  endtask

  task automatic test_wrong_device();
    logic [255:0] d;
    logic         a;
    int           acks = 0;
    applyReset();
    @(negedge Clk);
    bus.address = 16'h1002;
    bus.DataIn  = PAT_B;
    bus.nRead   = 1'b0;
    @(negedge Clk); if (bus.Ack === 1'b1) acks++;
    bus.nRead = 1'b1;
    @(negedge Clk); if (bus.Ack === 1'b1) acks++;
    bus.nWrite = 1'b0;
    @(negedge Clk); if (bus.Ack === 1'b1) acks++;
    bus.nWrite = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      if (bus.Ack === 1'b1) acks++;
    end
    checks++; if (acks != 0) begin failures++; $display("[TB] FAIL dev_acks: got %0d expected 0", acks); end
    checks++; if (bus.ReadCount !== 16'd0 || bus.WriteCount !== 16'd0 || bus.Err !== 1'b0) begin failures++; $display("[TB] FAIL dev_state: got r=%h w=%h err=%b expected 0/0/0", bus.ReadCount, bus.WriteCount, bus.Err); end
    doRead(16'h0002, d, a);
    checks++; if (a !== 1'b1 || d !== 256'h0) begin failures++; $display("[TB] FAIL dev_mem_intact: got ack=%b data=%h expected ack=1 data=0", a, d); end
  endtask

  task automatic test_back_to_back();
    logic [255:0] d;
    logic         a;
    int           acks = 0;
    applyReset();
    doWrite(16'h0005, PAT_A);
    @(negedge Clk);
    bus.address = 16'h0005;
    bus.nRead   = 1'b0;
    @(negedge Clk);
    bus.nRead  = 1'b1;
    bus.DataIn = PAT_B;
    bus.nWrite = 1'b0;
    @(negedge Clk);
    checks++; if (bus.Ack !== 1'b1 || bus.DataOut !== PAT_A) begin failures++; $display("[TB] FAIL b2b_read: got ack=%b data=%h expected ack=1 data=%h", bus.Ack, bus.DataOut, PAT_A); end
    bus.nWrite = 1'b1;
    @(negedge Clk);
    checks++; if (bus.Ack !== 1'b0 || bus.Err !== 1'b1) begin failures++; $display("[TB] FAIL b2b_drop: got ack=%b err=%b expected 0/1", bus.Ack, bus.Err); end
    doRead(16'h0005, d, a);
    checks++; if (d !== PAT_A || bus.WriteCount !== 16'd1 || bus.ReadCount !== 16'd2) begin failures++; $display("[TB] FAIL b2b_mem: got data=%h w=%h r=%h expected data=%h w=1 r=2", d, bus.WriteCount, bus.ReadCount, PAT_A); end
    applyReset();
    @(negedge Clk);
    bus.address = 16'h0001;
    bus.DataIn  = PAT_C;
    bus.nRead   = 1'b0;
    bus.nWrite  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      if (bus.Ack === 1'b1) acks++;
    end
    bus.nRead  = 1'b1;
    bus.nWrite = 1'b1;
    checks++; if (acks != 0 || bus.Err !== 1'b1 || bus.ReadCount !== 16'd0 || bus.WriteCount !== 16'd0) begin failures++; $display("[TB] FAIL collision: got acks=%0d err=%b r=%h w=%h expected 0/1/0/0", acks, bus.Err, bus.ReadCount, bus.WriteCount); end
    doRead(16'h0001, d, a);
    checks++; if (d !== 256'h0) begin failures++; $display("[TB] FAIL collision_mem: got %h expected 0", d); end
  endtask

  task automatic test_reset_abort();
    logic [255:0] d;
    logic         a;
    int           acks = 0;
    applyReset();
    doWrite(16'h0004, PAT_A);
    doWrite(16'h000B, PAT_B);
    @(negedge Clk);
    bus.address = 16'h0004;
    bus.nRead   = 1'b0;
    @(negedge Clk);
    bus.nRead = 1'b1;
    Reset     = 1'b1;
    #1;
    checks++; if (bus.Ack !== 1'b0 || bus.DataOut !== 256'h0) begin failures++; $display("[TB] FAIL abort_now: got ack=%b data=%h expected 0/0", bus.Ack, bus.DataOut); end
    @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      if (bus.Ack === 1'b1) acks++;
    end
    checks++; if (acks != 0 || bus.ReadCount !== 16'd0 || bus.WriteCount !== 16'd0) begin failures++; $display("[TB] FAIL abort_after: got acks=%0d r=%h w=%h expected 0/0/0", acks, bus.ReadCount, bus.WriteCount); end
    @(negedge Clk);
    bus.address = 16'h0006;
    bus.DataIn  = PAT_C;
    bus.nWrite  = 1'b0;
    @(negedge Clk);
    Reset      = 1'b1;
    bus.nWrite = 1'b1;
    @(negedge Clk);
    bus.address = 16'h0000;
    bus.nRead   = 1'b0;
    Reset       = 1'b0;
    @(negedge Clk);
    checks++; if (bus.Ack !== 1'b0) begin failures++; $display("[TB] FAIL held_reset_array: got ack=%b expected 0", bus.Ack); end
    @(negedge Clk);
    checks++; if (bus.Ack !== 1'b1 || bus.ReadCount !== 16'd1) begin failures++; $display("[TB] FAIL held_reset_read: got ack=%b r=%h expected 1/1", bus.Ack, bus.ReadCount); end
    bus.nRead = 1'b1;
    @(negedge Clk);
    for (int i = 0; i < 12; i++) begin
      doRead(16'(i), d, a);
      checks++; if (a !== 1'b1 || d !== 256'h0) begin failures++; $display("[TB] FAIL cleared_word%0d: got ack=%b data=%h expected ack=1 data=0", i, a, d); end
    end
  endtask

  task automatic test_saturation();
    logic [255:0] d;
    logic         a;
    applyReset();
    @(negedge Clk);
    force dut.writeCount = 16'hFFFD;
    @(negedge Clk);
    release dut.writeCount;
    doWrite(16'h0002, PAT_A);
    checks++; if (bus.WriteCount !== 16'hFFFE) begin failures++; $display("[TB] FAIL sat_step: got %h expected fffe", bus.WriteCount); end
    doWrite(16'h0002, PAT_B);
    checks++; if (bus.WriteCount !== 16'hFFFF) begin failures++; $display("[TB] FAIL sat_reach: got %h expected ffff", bus.WriteCount); end
    doWrite(16'h0002, PAT_C);
    checks++; if (bus.WriteCount !== 16'hFFFF) begin failures++; $display("[TB] FAIL sat_hold: got %h expected ffff", bus.WriteCount); end
    doRead(16'h0002, d, a);
    checks++; if (d !== PAT_C || bus.ReadCount !== 16'd1) begin failures++; $display("[TB] FAIL sat_data: got data=%h r=%h expected data=%h r=1", d, bus.ReadCount, PAT_C); end
  endtask

  initial begin
    Reset       = 1'b1;
    bus.nRead   = 1'b1;
    bus.nWrite  = 1'b1;
    bus.address = 16'h0;
    bus.DataIn  = 256'h0;
    test_reset();
    test_write_read();
    test_held_read();
    test_out_of_range();
    test_wrong_device();
    test_back_to_back();
    test_reset_abort();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
